// File: rtl/gray_input_conditioner.sv
// -----------------------------------------------------------------------------
// gray_input_conditioner
//
// Conditions the four raw Gray-code switch levels before they reach the
// Gray-to-display converter. Each bit is synchronized to clk through a
// SYNC_STAGES-deep flop chain and then debounced by its own counter. The
// debounced word is presented on gray_stable. Every change of that word is
// flagged with a one-cycle valid strobe. The change is also classified as
// Gray-adjacent (one bit) or not (gray_error).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   gray_raw     raw switch levels (bit3=ag, bit2=bg, bit1=cg, bit0=dg),
//                asynchronous to clk
//   gray_stable  debounced Gray word for the converter stage
//   valid        one-cycle pulse in the cycle gray_stable takes a new value
//   gray_error   set when the last update changed more than one bit;
//                only updated together with valid
//   busy         high while any bit's debounce counter is nonzero
//
// Every output is a flop or a function of flops only; nothing on gray_raw
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module gray_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_raw,
  output logic [WIDTH-1:0] gray_stable,
  output logic             valid,
  output logic             gray_error,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer chain: stage 0 samples gray_raw, the last stage is the
  // synchronized value used by the debouncers.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_last;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic                        valid_q, valid_d;
  logic                        error_q, error_d;

  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] disagree;
  logic [WIDTH-1:0] cnt_nz;

  assign sync_d[0]  = gray_raw;
  assign sync_last  = sync_q[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      assign disagree[gi] = sync_last[gi] ^ stable_q[gi];
      // The bit flips on the edge where it has already disagreed for
      // DEBOUNCE_CYCLES-1 counted cycles and still disagrees.
      assign flip[gi]     = disagree[gi] && (cnt_q[gi] == CNT_MAX);
      // Agreement (or a completed flip) restarts the count, so any glitch
      // shorter than the debounce window leaves no trace.
      assign cnt_d[gi]    = (!disagree[gi] || flip[gi]) ? '0
                                                        : cnt_q[gi] + CNT_W'(1);
      assign cnt_nz[gi]   = (cnt_q[gi] != '0);
    end
  endgenerate

  always_comb begin
    stable_d = stable_q ^ flip;
    valid_d  = |flip;
    error_d  = error_q;
    if (|flip) begin
      // Nonzero after clearing the lowest set bit means two or more flips.
      error_d = |(flip & (flip - WIDTH'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign gray_stable = stable_q;
  assign valid       = valid_q;
  assign gray_error  = error_q;
  assign busy        = |cnt_nz;

endmodule

// File: tb/tb_gray_input_conditioner.sv
// -----------------------------------------------------------------------------
// Directed testbench for gray_input_conditioner with SYNC_STAGES=2 and
// DEBOUNCE_CYCLES=4, so a steady raw change lands on gray_stable 6 edges
// after the first edge that samples it. Inputs change and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gray_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_raw;
  logic [3:0] gray_stable;
  logic       valid;
  logic       gray_error;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_input_conditioner #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_raw   (gray_raw),
    .gray_stable(gray_stable),
    .valid      (valid),
    .gray_error (gray_error),
    .busy       (busy)
  );

  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; gray_raw = 4'b1111;
    step(1);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL reset_stable got %b exp 0000", gray_stable); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", valid); end
    vectors++; if (gray_error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b exp 0", gray_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    step(2);
    rst = 1'b0;
    step(5);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL pwr_early got %b exp 0000", gray_stable); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL pwr_early_valid got %b exp 0", valid); end
    step(1);
    vectors++; if (gray_stable !== 4'b1111) begin miscompares++; $display("FAIL pwr_stable got %b exp 1111", gray_stable); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL pwr_valid got %b exp 1", valid); end
    vectors++; if (gray_error !== 1'b1) begin miscompares++; $display("FAIL pwr_error got %b exp 1", gray_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pwr_busy got %b exp 0", busy); end
    step(1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL pwr_valid_drop got %b exp 0", valid); end
    vectors++; if (gray_error !== 1'b1) begin miscompares++; $display("FAIL pwr_error_hold got %b exp 1", gray_error); end
    $display("test_reset done: stable=%b valid=%b error=%b", gray_stable, valid, gray_error);
  endtask

  task automatic test_clean_step;
    gray_raw = 4'b0000;
    step(8);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL step_base got %b exp 0000", gray_stable); end
    gray_raw = 4'b0001;
    step(3);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL step_busy got %b exp 1", busy); end
    step(2);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL step_early got %b exp 0000", gray_stable); end
    step(1);
    vectors++; if (gray_stable !== 4'b0001) begin miscompares++; $display("FAIL step_stable got %b exp 0001", gray_stable); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL step_valid got %b exp 1", valid); end
    vectors++; if (gray_error !== 1'b0) begin miscompares++; $display("FAIL step_error got %b exp 0", gray_error); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL step_busy_end got %b exp 0", busy); end
    step(1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL step_valid_drop got %b exp 0", valid); end
    $display("test_clean_step done: stable=%b", gray_stable);
  endtask

  task automatic test_glitch;
    int pulses;
    pulses = 0;
    gray_raw = 4'b0000;
    step(8);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL glitch_base got %b exp 0000", gray_stable); end
    gray_raw = 4'b0001;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      if (valid) pulses++;
    end
    gray_raw = 4'b0000;
    for (int e = 4; e <= 10; e++) begin
      step(1);
      if (valid) pulses++;
      if (e == 5) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
      end
      if (e == 6) begin
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_lo got %b exp 0", busy); end
      end
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL glitch_pulses got %0d exp 0", pulses); end
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL glitch_stable got %b exp 0000", gray_stable); end
    $display("test_glitch done: pulses=%0d stable=%b", pulses, gray_stable);
  endtask

  task automatic test_gray_sequence;
    gray_raw = 4'b0001;
    step(8);
    vectors++; if (gray_stable !== 4'b0001) begin miscompares++; $display("FAIL seq_base got %b exp 0001", gray_stable); end
    gray_raw = 4'b0011;
    step(6);
    vectors++; if (gray_stable !== 4'b0011) begin miscompares++; $display("FAIL seq_0011 got %b exp 0011", gray_stable); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL seq_0011_valid got %b exp 1", valid); end
    vectors++; if (gray_error !== 1'b0) begin miscompares++; $display("FAIL seq_0011_error got %b exp 0", gray_error); end
    step(2);
    gray_raw = 4'b0110;
    step(6);
    vectors++; if (gray_stable !== 4'b0110) begin miscompares++; $display("FAIL seq_0110 got %b exp 0110", gray_stable); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL seq_0110_valid got %b exp 1", valid); end
    vectors++; if (gray_error !== 1'b1) begin miscompares++; $display("FAIL seq_0110_error got %b exp 1", gray_error); end
    step(1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL seq_valid_drop got %b exp 0", valid); end
    step(3);
    vectors++; if (gray_error !== 1'b1) begin miscompares++; $display("FAIL seq_error_hold got %b exp 1", gray_error); end
    gray_raw = 4'b0111;
    step(6);
    vectors++; if (gray_stable !== 4'b0111) begin miscompares++; $display("FAIL seq_0111 got %b exp 0111", gray_stable); end
    vectors++; if (gray_error !== 1'b0) begin miscompares++; $display("FAIL seq_0111_error got %b exp 0", gray_error); end
    $display("test_gray_sequence done: stable=%b error=%b", gray_stable, gray_error);
  endtask

  task automatic test_simultaneous;
    int pulses;
    pulses = 0;
    // Walk back to 0000 one bit at a time so gray_error starts cleared.
    gray_raw = 4'b0110; step(8);
    gray_raw = 4'b0010; step(8);
    gray_raw = 4'b0000; step(8);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL sim_base got %b exp 0000", gray_stable); end
    vectors++; if (gray_error !== 1'b0) begin miscompares++; $display("FAIL sim_base_error got %b exp 0", gray_error); end
    gray_raw = 4'b0011;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (valid) pulses++;
      if (e == 6) begin
        vectors++; if (gray_stable !== 4'b0011) begin miscompares++; $display("FAIL sim_stable got %b exp 0011", gray_stable); end
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL sim_valid got %b exp 1", valid); end
        vectors++; if (gray_error !== 1'b1) begin miscompares++; $display("FAIL sim_error got %b exp 1", gray_error); end
      end
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL sim_pulses got %0d exp 1", pulses); end
    $display("test_simultaneous done: pulses=%0d stable=%b", pulses, gray_stable);
  endtask

  task automatic test_mid_reset;
    gray_raw = 4'b0000;
    step(8);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL mid_base got %b exp 0000", gray_stable); end
    gray_raw = 4'b0001;
    step(4);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst = 1'b1;
    step(1);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_stable got %b exp 0000", gray_stable); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    rst = 1'b0;
    step(5);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL mid_early got %b exp 0000", gray_stable); end
    step(1);
    vectors++; if (gray_stable !== 4'b0001) begin miscompares++; $display("FAIL mid_stable got %b exp 0001", gray_stable); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got %b exp 1", valid); end
    // Reset landing on the very edge where the counter would expire.
    gray_raw = 4'b0000;
    step(8);
    gray_raw = 4'b0001;
    step(5);
    rst = 1'b1;
    step(1);
    vectors++; if (gray_stable !== 4'b0000) begin miscompares++; $display("FAIL exp_rst_stable got %b exp 0000", gray_stable); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL exp_rst_valid got %b exp 0", valid); end
    rst = 1'b0;
    step(6);
    vectors++; if (gray_stable !== 4'b0001) begin miscompares++; $display("FAIL exp_recover got %b exp 0001", gray_stable); end
    $display("test_mid_reset done: stable=%b", gray_stable);
  endtask

  initial begin
    rst = 1'b1;
    gray_raw = 4'b0000;
    @(negedge clk);
    test_reset();
    test_clean_step();
    test_glitch();
    test_gray_sequence();
    test_simultaneous();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_input_conditioner.md
Name: gray_input_conditioner

Overview:
Input-conditioning stage directly upstream of the Gray-to-display top level. It takes the four raw Gray-code switch levels (ag, bg, cg, dg) and synchronizes each bit to clk, then debounces it. It delivers a clean, stable 4-bit Gray word to the converter/display stage. It also emits a one-cycle update strobe and a Gray-adjacency error flag whenever the stable word changes.

Parameters:
WIDTH, 4, number of Gray bits conditioned.
SYNC_STAGES, 2, flip-flops in each bit's synchronizer chain (>=2).
DEBOUNCE_CYCLES, 270000, consecutive clk cycles a synchronized bit must disagree with its stable value before the stable value flips; this is 10 ms at 27 MHz (>=2).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
gray_raw  input  WIDTH  raw switch levels; bit3=ag, bit2=bg, bit1=cg, bit0=dg; asynchronous to clk
gray_stable  output  WIDTH  debounced Gray word; feeds ag..dg of the converter stage
valid  output  1  one-cycle pulse, high in the cycle gray_stable takes a new value
gray_error  output  1  high if the last update changed more than one bit; updated only with valid
busy  output  1  high while any bit's debounce counter is nonzero

Behaviour:
- Reset (rst=1 at a rising edge):
  - All synchronizer flops, counters, gray_stable, valid, gray_error and busy go to 0 at that edge.
  - rst has priority over all other activity, including a counter about to expire.
- Synchronizer: each bit passes through SYNC_STAGES flops. sync[i] is the last stage.
- Per-bit debounce counter cnt[i], width $clog2(DEBOUNCE_CYCLES). At each edge:
  - If sync[i]==gray_stable[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: gray_stable[i]<=~gray_stable[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- Latency: a raw change held steady appears on gray_stable exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it, counting that sampling edge.
- Glitch rejection: any return to agreement before expiry clears the counter. A pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches gray_stable.
- Word update: compute flips = set of bits flipping at this edge (any nonzero flip vector).
  - valid is registered high for exactly the following cycle.
  - gray_error<=(popcount(flips)>1).
  - Multiple bits flipping on the same edge count as one update with one valid pulse.
  - With no flips, valid<=0 and gray_error holds its value.
- Back-to-back updates on consecutive edges produce consecutive valid pulses. Each error evaluation compares only against the immediately previous gray_stable.
- busy is the OR of (cnt[i]!=0). It is a registered-derived signal with no combinational path from gray_raw.
- No combinational path from any input to any output.

Test Plan:
1. Power-up: bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Hold rst=1 for 3 edges with gray_raw=4'b1111 -> all outputs 0. Release rst; gray_stable=4'b1111 after the 6th edge. valid=1 for one cycle, gray_error=1 (4 bits changed).
2. Clean step: from a stable 4'b0000, set gray_raw=4'b0001 and hold -> gray_stable=4'b0001 after 6 edges. valid one-cycle pulse, gray_error=0, busy high during counting.
3. Glitch: from 4'b0000, raise bit0 for 3 cycles, then drop it -> no valid pulse, gray_stable stays 4'b0000, busy returns to 0 two edges after the drop reaches sync.
4. Gray sequence 0001->0011 -> valid, gray_error=0. Then 0011->0110 -> bits 2 and 0 flip on the same edge, one valid pulse, gray_error=1. gray_error holds 1 until the next update.
5. Simultaneous change: raw 0000->0011 in one cycle -> both bits flip on the same edge, a single valid pulse, gray_error=1.
6. Mid-debounce reset: with cnt[0]=2 pending, assert rst for one edge -> counters 0, gray_stable 0, no valid. With raw still 0001 after release, the update arrives a full 6 edges later.
